// File: rtl/sorted_list_reader.sv
// Snapshots a 16-slot sorted list on start and streams the records, rank 1 first,
// over a valid/ready handshake, optionally skipping all-zero slots.
module sorted_list_reader #(
  parameter int NUM_ENTRIES = 16,
  parameter bit SKIP_EMPTY  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [31:0] sorted_data1,
  input  logic [31:0] sorted_data2,
  input  logic [31:0] sorted_data3,
  input  logic [31:0] sorted_data4,
  input  logic [31:0] sorted_data5,
  input  logic [31:0] sorted_data6,
  input  logic [31:0] sorted_data7,
  input  logic [31:0] sorted_data8,
  input  logic [31:0] sorted_data9,
  input  logic [31:0] sorted_data10,
  input  logic [31:0] sorted_data11,
  input  logic [31:0] sorted_data12,
  input  logic [31:0] sorted_data13,
  input  logic [31:0] sorted_data14,
  input  logic [31:0] sorted_data15,
  input  logic [31:0] sorted_data16,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic [4:0]  sent_count
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                 state_q, state_d;
  logic [NUM_ENTRIES-1:0] mask_q, mask_d;
  logic [4:0]             sent_count_q, sent_count_d;
  logic [31:0]            snap_q [NUM_ENTRIES];
  logic [31:0]            snap_d [NUM_ENTRIES];
  logic [31:0]            slot_in [NUM_ENTRIES];

  logic [IDX_W-1:0]       low_idx;
  logic [NUM_ENTRIES-1:0] mask_rest;
  logic                   xfer;

  always_comb begin
    slot_in[0]  = sorted_data1;
    slot_in[1]  = sorted_data2;
    slot_in[2]  = sorted_data3;
    slot_in[3]  = sorted_data4;
    slot_in[4]  = sorted_data5;
    slot_in[5]  = sorted_data6;
    slot_in[6]  = sorted_data7;
    slot_in[7]  = sorted_data8;
    slot_in[8]  = sorted_data9;
    slot_in[9]  = sorted_data10;
    slot_in[10] = sorted_data11;
    slot_in[11] = sorted_data12;
    slot_in[12] = sorted_data13;
    slot_in[13] = sorted_data14;
    slot_in[14] = sorted_data15;
    slot_in[15] = sorted_data16;
  end

  // Scanning downwards leaves the lowest set index as the final winner.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = IDX_W'(i);
    end
  end

  // Mask with its lowest set bit removed; zero means the current record is the last.
  assign mask_rest = mask_q & (mask_q - NUM_ENTRIES'(1));

  assign out_valid  = (state_q == SEND) & (|mask_q) & en;
  assign out_data   = out_valid ? snap_q[low_idx] : 32'h0;
  assign out_last   = out_valid & (mask_rest == '0);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign sent_count = sent_count_q;
  assign xfer       = out_valid & out_ready;

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    mask_d       = mask_q;
    sent_count_d = sent_count_q;
    snap_d       = snap_q;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_d = slot_in;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
              mask_d[i] = SKIP_EMPTY ? (slot_in[i] != 32'h0) : 1'b1;
            end
            sent_count_d = 5'd0;
            state_d      = SEND;
          end
        end
        SEND: begin
          if (mask_q == '0) begin
            state_d = DONE;
          end else if (xfer) begin
            mask_d       = mask_rest;
            sent_count_d = sent_count_q + 5'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      sent_count_q <= 5'd0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      sent_count_q <= sent_count_d;
    end
  end

  // NOTE: the snapshot is deliberately left out of reset; the cleared mask already
  // hides its contents, and leaving memories unreset keeps them as plain storage.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

endmodule
